// File: rtl/perceptron_core_if.sv
// AXI4-Lite weight-load port plus the sample-in / result-out handshake of perceptron_core.
// The slave modport is the core's view; master is the view of whatever drives it.
interface perceptron_core_if;
   logic [31:0] S_AXI_awaddr;
   logic [2:0]  S_AXI_awprot;
   logic        S_AXI_awvalid;
   logic        S_AXI_awready;
   logic [31:0] S_AXI_wdata;
   logic [3:0]  S_AXI_wstrb;
   logic        S_AXI_wvalid;
   logic        S_AXI_wready;
   logic [1:0]  S_AXI_bresp;
   logic        S_AXI_bvalid;
   logic        S_AXI_bready;
   logic [31:0] S_AXI_araddr;
   logic [2:0]  S_AXI_arprot;
   logic        S_AXI_arvalid;
   logic        S_AXI_arready;
   logic [31:0] S_AXI_rdata;
   logic [1:0]  S_AXI_rresp;
   logic        S_AXI_rvalid;
   logic        S_AXI_rready;
   logic        start;
   logic [31:0] x_tdata;
   logic        x_tvalid;
   logic        x_tready;
   logic [31:0] bias;
   logic [31:0] a_tdata;
   logic        done;

   modport slave (
      input  S_AXI_awaddr, S_AXI_awprot, S_AXI_awvalid, S_AXI_wdata, S_AXI_wstrb, S_AXI_wvalid,
      input  S_AXI_bready, S_AXI_araddr, S_AXI_arprot, S_AXI_arvalid, S_AXI_rready,
      output S_AXI_awready, S_AXI_wready, S_AXI_bresp, S_AXI_bvalid,
      output S_AXI_arready, S_AXI_rdata, S_AXI_rresp, S_AXI_rvalid,
      input  start, x_tdata, x_tready, bias,
      output x_tvalid, a_tdata, done
   );

   modport master (
      output S_AXI_awaddr, S_AXI_awprot, S_AXI_awvalid, S_AXI_wdata, S_AXI_wstrb, S_AXI_wvalid,
      output S_AXI_bready, S_AXI_araddr, S_AXI_arprot, S_AXI_arvalid, S_AXI_rready,
      input  S_AXI_awready, S_AXI_wready, S_AXI_bresp, S_AXI_bvalid,
      input  S_AXI_arready, S_AXI_rdata, S_AXI_rresp, S_AXI_rvalid,
      output start, x_tdata, x_tready, bias,
      input  x_tvalid, a_tdata, done
   );
endinterface

// File: rtl/perceptron_core.sv
// Single-neuron MAC: weights loaded over AXI4-Lite into a dual-port RAM, then
// N_INPUTS streamed samples are accumulated as sum(w[k]*x[k] + bias), modulo 2^32.
module perceptron_core #(
   parameter int N_INPUTS   = 5,
   parameter int ADDR_WIDTH = 10
) (
   input  logic             s_axi_aclk,
   input  logic             s_axi_areset,
   perceptron_core_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CNT_W = ADDR_WIDTH + 1;
   localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N_INPUTS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_e;

   function automatic logic [31:0] mac_wrap(input logic [31:0] acc, input logic [31:0] w,
                                            input logic [31:0] x, input logic [31:0] b);
      logic [31:0] prod;
      prod = w * x;
      return acc + prod + b;
   endfunction

   logic [31:0] mem_q [DEPTH];

   logic                  wr_rdy_q, bvalid_q, rd_rdy_q, rvalid_q;
   logic [31:0]           rdata_q;
   logic                  wr_fire, rd_fire;
   logic [ADDR_WIDTH-1:0] wr_idx, rd_idx;

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      k_q, k_d;
   logic [31:0]           acc_q, acc_d, a_q, a_d, wgt_q;
   logic                  done_q, done_d;
   logic                  xfer, wgt_load;
   logic [ADDR_WIDTH-1:0] addr_b;

   logic unused_bits;
   assign unused_bits = ^{bus.S_AXI_awaddr[31:ADDR_WIDTH+2], bus.S_AXI_awaddr[1:0],
                          bus.S_AXI_araddr[31:ADDR_WIDTH+2], bus.S_AXI_araddr[1:0],
                          bus.S_AXI_awprot, bus.S_AXI_arprot};

   assign wr_idx  = bus.S_AXI_awaddr[ADDR_WIDTH+1:2];
   assign rd_idx  = bus.S_AXI_araddr[ADDR_WIDTH+1:2];
   assign wr_fire = wr_rdy_q & bus.S_AXI_awvalid & bus.S_AXI_wvalid & ~s_axi_areset;
   assign rd_fire = rd_rdy_q & bus.S_AXI_arvalid;

   // AXI slave: ready is a one-cycle registered pulse, blocked while a response is pending
   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         wr_rdy_q <= 1'b0;
         bvalid_q <= 1'b0;
         rd_rdy_q <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         wr_rdy_q <= bus.S_AXI_awvalid & bus.S_AXI_wvalid & ~bvalid_q & ~wr_rdy_q;
         if (wr_fire) begin
            bvalid_q <= 1'b1;
         end else if (bus.S_AXI_bready) begin
            bvalid_q <= 1'b0;
         end
         rd_rdy_q <= bus.S_AXI_arvalid & ~rvalid_q & ~rd_rdy_q;
         if (rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= mem_q[rd_idx];
         end else if (bus.S_AXI_rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   assign bus.S_AXI_awready = wr_rdy_q;
   assign bus.S_AXI_wready  = wr_rdy_q;
   assign bus.S_AXI_bvalid  = bvalid_q;
   assign bus.S_AXI_bresp   = 2'b00;
   assign bus.S_AXI_arready = rd_rdy_q;
   assign bus.S_AXI_rvalid  = rvalid_q;
   assign bus.S_AXI_rdata   = rdata_q;
   assign bus.S_AXI_rresp   = 2'b00;

   // Weight RAM: byte-enabled AXI write port, compute read port loads only at fetch/transfer
   always_ff @(posedge s_axi_aclk) begin
      if (wr_fire) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.S_AXI_wstrb[b]) begin
               mem_q[wr_idx][8*b +: 8] <= bus.S_AXI_wdata[8*b +: 8];
            end
         end
      end
      if (wgt_load) begin
         wgt_q <= mem_q[addr_b];
      end
   end

   assign xfer   = (state_q == RUN) & bus.x_tready;
   assign addr_b = k_d[ADDR_WIDTH-1:0];

   always_comb begin
      state_d  = state_q;
      k_d      = k_q;
      acc_d    = acc_q;
      a_d      = a_q;
      done_d   = done_q;
      wgt_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d  = FETCH;
               k_d      = '0;
               acc_d    = '0;
               done_d   = 1'b0;
               wgt_load = 1'b1;
            end
         end
         FETCH: state_d = RUN;
         RUN: begin
            if (xfer) begin
               acc_d    = mac_wrap(acc_q, wgt_q, bus.x_tdata, bus.bias);
               k_d      = k_q + CNT_W'(1);
               wgt_load = 1'b1;
               if (k_q == LAST_K) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            a_d    = acc_q;
            done_d = 1'b1;
            if (!bus.start) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge s_axi_aclk) begin
      if (s_axi_areset) begin
         state_q <= IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         done_q  <= done_d;
      end
   end

   assign bus.x_tvalid = (state_q == RUN);
   assign bus.a_tdata  = a_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_perceptron_core.sv
// Directed bench: AXI load/readback, full-rate and stalled evaluations, byte strobes,
// mid-run reset, multiply wrap (N_INPUTS=1 instance) and address aliasing.
module tb_perceptron_core;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] xs [5];

   always #5 clk = ~clk;

   perceptron_core_if if0 ();
   perceptron_core_if if1 ();

   perceptron_core #(.N_INPUTS(5), .ADDR_WIDTH(10)) u_dut (
      .s_axi_aclk(clk), .s_axi_areset(rst), .bus(if0.slave));
   perceptron_core #(.N_INPUTS(1), .ADDR_WIDTH(10)) u_dut1 (
      .s_axi_aclk(clk), .s_axi_areset(rst), .bus(if1.slave));

   // The N_INPUTS=1 instance sees exactly the same input stimulus as the main one
   assign if1.S_AXI_awaddr  = if0.S_AXI_awaddr;
   assign if1.S_AXI_awprot  = if0.S_AXI_awprot;
   assign if1.S_AXI_awvalid = if0.S_AXI_awvalid;
   assign if1.S_AXI_wdata   = if0.S_AXI_wdata;
   assign if1.S_AXI_wstrb   = if0.S_AXI_wstrb;
   assign if1.S_AXI_wvalid  = if0.S_AXI_wvalid;
   assign if1.S_AXI_bready  = if0.S_AXI_bready;
   assign if1.S_AXI_araddr  = if0.S_AXI_araddr;
   assign if1.S_AXI_arprot  = if0.S_AXI_arprot;
   assign if1.S_AXI_arvalid = if0.S_AXI_arvalid;
   assign if1.S_AXI_rready  = if0.S_AXI_rready;
   assign if1.start         = if0.start;
   assign if1.x_tdata       = if0.x_tdata;
   assign if1.x_tready      = if0.x_tready;
   assign if1.bias          = if0.bias;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb);
      int t;
      @(negedge clk);
      if0.S_AXI_awaddr = addr; if0.S_AXI_wdata = data; if0.S_AXI_wstrb = strb;
      if0.S_AXI_awvalid = 1'b1; if0.S_AXI_wvalid = 1'b1;
      t = 0;
      while (!(if0.S_AXI_awready && if0.S_AXI_wready) && t < 100) begin
         @(negedge clk); t++;
      end
      check_val("aw_w_ready", {31'd0, if0.S_AXI_awready & if0.S_AXI_wready}, 32'd1);
      @(negedge clk);
      if0.S_AXI_awvalid = 1'b0; if0.S_AXI_wvalid = 1'b0;
      if0.S_AXI_bready = 1'b1;
      t = 0;
      while (!if0.S_AXI_bvalid && t < 100) begin
         @(negedge clk); t++;
      end
      check_val("bvalid", {31'd0, if0.S_AXI_bvalid}, 32'd1);
      check_val("bresp", {30'd0, if0.S_AXI_bresp}, 32'd0);
      @(negedge clk);
      if0.S_AXI_bready = 1'b0;
   endtask

   task automatic axi_read_check(input string tag, input logic [31:0] addr,
                                 input logic [31:0] exp);
      int t;
      @(negedge clk);
      if0.S_AXI_araddr = addr; if0.S_AXI_arvalid = 1'b1;
      t = 0;
      while (!if0.S_AXI_arready && t < 100) begin
         @(negedge clk); t++;
      end
      check_val("arready", {31'd0, if0.S_AXI_arready}, 32'd1);
      @(negedge clk);
      if0.S_AXI_arvalid = 1'b0;
      // Hold rready low a while: rvalid and rdata must stay put
      repeat (2) @(negedge clk);
      check_val("rvalid", {31'd0, if0.S_AXI_rvalid}, 32'd1);
      check_val(tag, if0.S_AXI_rdata, exp);
      check_val("rresp", {30'd0, if0.S_AXI_rresp}, 32'd0);
      if0.S_AXI_rready = 1'b1;
      @(negedge clk);
      if0.S_AXI_rready = 1'b0;
      check_val("rvalid_clr", {31'd0, if0.S_AXI_rvalid}, 32'd0);
   endtask

   task automatic run_eval(input logic [31:0] b, input bit stall, output logic [31:0] res,
                           output int lat, output int drops, output int nxfer);
      int  cyc;
      bit  fire, seen_run;
      cyc = 0; drops = 0; nxfer = 0; seen_run = 1'b0;
      @(negedge clk);
      if0.bias = b; if0.start = 1'b1; if0.x_tdata = xs[0];
      if0.x_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      while (cyc < 300) begin
         fire = if0.x_tvalid && if0.x_tready;
         @(posedge clk);
         cyc++;
         if (fire) nxfer++;
         @(negedge clk);
         if (if0.done) break;
         if (seen_run && nxfer < 5 && !if0.x_tvalid) drops++;
         if (if0.x_tvalid) seen_run = 1'b1;
         if0.x_tdata  = xs[nxfer % 5];
         if0.x_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      check_val("done", {31'd0, if0.done}, 32'd1);
      res = if0.a_tdata;
      lat = cyc - 1;
   endtask

   task automatic finish_eval();
      @(negedge clk);
      if0.start = 1'b0; if0.x_tready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [31:0] res;
      int          lat, drops, nxfer;
      if0.S_AXI_awaddr = '0; if0.S_AXI_awprot = '0; if0.S_AXI_awvalid = 1'b0;
      if0.S_AXI_wdata  = '0; if0.S_AXI_wstrb  = '0; if0.S_AXI_wvalid  = 1'b0;
      if0.S_AXI_bready = 1'b0;
      if0.S_AXI_araddr = '0; if0.S_AXI_arprot = '0; if0.S_AXI_arvalid = 1'b0;
      if0.S_AXI_rready = 1'b0;
      if0.start = 1'b0; if0.x_tdata = '0; if0.x_tready = 1'b0; if0.bias = '0;

      repeat (3) @(negedge clk);
      check_val("rst_awready", {31'd0, if0.S_AXI_awready}, 32'd0);
      check_val("rst_bvalid", {31'd0, if0.S_AXI_bvalid}, 32'd0);
      check_val("rst_arready", {31'd0, if0.S_AXI_arready}, 32'd0);
      check_val("rst_rvalid", {31'd0, if0.S_AXI_rvalid}, 32'd0);
      check_val("rst_rdata", if0.S_AXI_rdata, 32'd0);
      check_val("rst_x_tvalid", {31'd0, if0.x_tvalid}, 32'd0);
      check_val("rst_a_tdata", if0.a_tdata, 32'd0);
      check_val("rst_done", {31'd0, if0.done}, 32'd0);
      rst = 1'b0;

      // Weight load with random gaps, then readback
      for (int i = 0; i < 5; i++) begin
         repeat ($urandom_range(0, 50)) @(negedge clk);
         axi_write(32'(4 * i), 32'(i + 1), 4'hF);
      end
      for (int i = 0; i < 5; i++) begin
         repeat ($urandom_range(0, 50)) @(negedge clk);
         axi_read_check("rd_weight", 32'(4 * i), 32'(i + 1));
      end

      // Full-rate evaluation: sum(k*k + 1), k=1..5 = 60
      for (int i = 0; i < 5; i++) xs[i] = 32'(i + 1);
      run_eval(32'd1, 1'b0, res, lat, drops, nxfer);
      check_val("acc_full", res, 32'd60);
      check_val("latency", 32'(lat), 32'd7);
      check_val("n_xfer", 32'(nxfer), 32'd5);
      check_val("dut1_acc", if1.a_tdata, 32'd2);
      finish_eval();

      // Random backpressure, bias 0: 55, x_tvalid held through stalls
      run_eval(32'd0, 1'b1, res, lat, drops, nxfer);
      check_val("acc_stall", res, 32'd55);
      check_val("tvalid_drops", 32'(drops), 32'd0);
      finish_eval();

      // Byte strobes
      axi_write(32'h14, 32'h0, 4'hF);
      axi_write(32'h14, 32'hFFFF_FFFF, 4'b0011);
      axi_read_check("rd_strb", 32'h14, 32'h0000_FFFF);

      // Reset in the middle of RUN, then a clean rerun
      @(negedge clk);
      if0.bias = 32'd7; if0.x_tdata = 32'd9; if0.x_tready = 1'b1; if0.start = 1'b1;
      repeat (4) @(negedge clk);
      check_val("mid_run_tvalid", {31'd0, if0.x_tvalid}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; if0.start = 1'b0; if0.x_tready = 1'b0;
      check_val("mid_rst_tvalid", {31'd0, if0.x_tvalid}, 32'd0);
      check_val("mid_rst_done", {31'd0, if0.done}, 32'd0);
      check_val("mid_rst_a", if0.a_tdata, 32'd0);
      @(negedge clk);
      run_eval(32'd1, 1'b0, res, lat, drops, nxfer);
      check_val("acc_after_rst", res, 32'd60);
      finish_eval();

      // 0x1000 aliases word 0; 0x80000000*2 wraps to 0
      axi_write(32'h1000, 32'h8000_0000, 4'hF);
      axi_read_check("rd_alias", 32'h0, 32'h8000_0000);
      xs[0] = 32'd2;
      for (int i = 1; i < 5; i++) xs[i] = 32'd1;
      run_eval(32'd0, 1'b0, res, lat, drops, nxfer);
      check_val("acc_wrap5", res, 32'd14);
      check_val("dut1_done", {31'd0, if1.done}, 32'd1);
      check_val("dut1_wrap", if1.a_tdata, 32'd0);
      finish_eval();
      check_val("done_held_idle", {31'd0, if0.done}, 32'd1);
      check_val("a_held_idle", if0.a_tdata, 32'd14);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
